// File: rtl/alu_cmd_ctrl_pkg.sv
// rtl/alu_cmd_ctrl_pkg.sv - shared state encoding and command constants for alu_cmd_ctrl
package alu_cmd_ctrl_pkg;

  localparam int FUN_W = 4;

  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_RD_FUN,
    ST_ALU_RUN,
    ST_SEND_LO,
    ST_SEND_HI
  } state_e;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - byte-command front end for an ALU: collects operands/function,
// fires the ALU, waits for its result with a timeout and streams it back as two bytes.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   rx_p_data_i,
  input  logic                    rx_d_vld_i,
  input  logic [2*DATA_WIDTH-1:0] alu_out_i,
  input  logic                    out_valid_i,
  input  logic                    tx_full_i,
  output logic [DATA_WIDTH-1:0]   alu_a_o,
  output logic [DATA_WIDTH-1:0]   alu_b_o,
  output logic [FUN_W-1:0]        alu_fun_o,
  output logic                    alu_en_o,
  output logic                    gate_en_o,
  output logic [DATA_WIDTH-1:0]   tx_p_data_o,
  output logic                    tx_d_vld_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [FUN_W-1:0]          alu_fun_q, alu_fun_d;
  logic                      alu_en_q, alu_en_d;
  logic                      err_q, err_d;
  logic [2*DATA_WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      alu_en_q  <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q  <= alu_en_d;
      err_q     <= err_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    alu_en_d  = 1'b0;
    err_d     = 1'b0;
    result_d  = result_q;
    cnt_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (rx_d_vld_i) begin
          if (rx_p_data_i == DATA_WIDTH'(CMD_ALU_OP)) begin
            state_d = ST_RD_A;
          end else if (rx_p_data_i == DATA_WIDTH'(CMD_ALU_NOP)) begin
            state_d = ST_RD_FUN;
          end
        end
      end
      ST_RD_A: begin
        if (rx_d_vld_i) begin
          alu_a_d = rx_p_data_i;
          state_d = ST_RD_B;
        end
      end
      ST_RD_B: begin
        if (rx_d_vld_i) begin
          alu_b_d = rx_p_data_i;
          state_d = ST_RD_FUN;
        end
      end
      ST_RD_FUN: begin
        if (rx_d_vld_i) begin
          alu_fun_d = rx_p_data_i[FUN_W-1:0];
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_RUN;
        end
      end
      ST_ALU_RUN: begin
        // A result arriving on the last counted cycle beats the timeout.
        if (out_valid_i) begin
          result_d = alu_out_i;
          state_d  = ST_SEND_LO;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SEND_LO: begin
        if (!tx_full_i) begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (!tx_full_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // TX write is combinational so the low byte goes out the cycle after OUT_VALID.
  always_comb begin
    tx_p_data_o = '0;
    tx_d_vld_o  = 1'b0;
    if (state_q == ST_SEND_LO) begin
      tx_p_data_o = result_q[DATA_WIDTH-1:0];
      tx_d_vld_o  = !tx_full_i;
    end else if (state_q == ST_SEND_HI) begin
      tx_p_data_o = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
      tx_d_vld_o  = !tx_full_i;
    end
  end

  assign alu_a_o   = alu_a_q;
  assign alu_b_o   = alu_b_q;
  assign alu_fun_o = alu_fun_q;
  assign alu_en_o  = alu_en_q;
  assign err_o     = err_q;
  assign gate_en_o = (state_q == ST_ALU_RUN);
  assign busy_o    = (state_q != ST_IDLE);

endmodule
